sr_latch_bank: RTL and testbench

//   Parametrised, clocked successor to the NOR SR latch: CH independent set/reset

---
 rtl/sr_latch_bank.sv | 84 ++++++++
 tb/tb_sr_latch_bank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_bank.sv
// Bank of CH clocked set/reset flags with a configurable S=R=1 resolution mode.
// Also provides optional edge-qualified inputs, rise pulses, sticky conflicts and a saturating conflict counter.
module sr_latch_bank #(
   parameter int CH    = 8,
   parameter int MODE  = 0,
   parameter int EDGE  = 0,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [CH-1:0]    s,
   input  logic [CH-1:0]    r,
   output logic [CH-1:0]    q,
   output logic [CH-1:0]    qb,
   output logic [CH-1:0]    rise,
   output logic [CH-1:0]    conflict,
   output logic [CNT_W-1:0] conflict_cnt,
   output logic             any_q
);

   logic [CH-1:0] s_d;
   logic [CH-1:0] r_d;
   logic [CH-1:0] se;
   logic [CH-1:0] re;
   logic [CH-1:0] q_next;
   logic          any_conf;

   always_comb begin
      se       = (EDGE != 0) ? (s & ~s_d) : s;
      re       = (EDGE != 0) ? (r & ~r_d) : r;
      any_conf = |(se & re);
      q_next   = q;
      for (int unsigned i = 0; i < CH; i++) begin
         case ({se[i], re[i]})
            2'b10: q_next[i] = 1'b1;
            2'b01: q_next[i] = 1'b0;
            2'b11: begin
               case (MODE)
                  0:       q_next[i] = 1'b0;
                  1:       q_next[i] = 1'b1;
                  3:       q_next[i] = ~q[i];
                  default: q_next[i] = q[i];
               endcase
            end
            default: q_next[i] = q[i];
         endcase
      end
   end

   assign qb    = ~q;
   assign any_q = |q;

   // Input history runs every cycle so edges seen while disabled are consumed, not deferred.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q            <= '0;
         rise         <= '0;
         conflict     <= '0;
         conflict_cnt <= '0;
         s_d          <= '0;
         r_d          <= '0;
      end else begin
         s_d <= s;
         r_d <= r;
         if (clr) begin
            q            <= '0;
            rise         <= '0;
            conflict     <= '0;
            conflict_cnt <= '0;
         end else if (en) begin
            q        <= q_next;
            rise     <= q_next & ~q;
            conflict <= conflict | (se & re);
            if (any_conf && (conflict_cnt != '1))
               conflict_cnt <= conflict_cnt + CNT_W'(1);
         end else begin
            rise <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Scoreboard bench: four sr_latch_bank configurations share one random/directed stimulus stream
// and are checked against a per-channel rule model kept in the bench.
module tb_sr_latch_bank;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic [7:0] s;
   logic [7:0] r;

   logic [7:0]  dq[4];
   logic [7:0]  dqb[4];
   logic [7:0]  drise[4];
   logic [7:0]  dconf[4];
   logic        dany[4];
   logic [31:0] dcnt[4];
   logic [3:0]  c0;
   logic [1:0]  c1;
   logic [1:0]  c2;
   logic [3:0]  c3;

   sr_latch_bank #(.CH(8), .MODE(0), .EDGE(0), .CNT_W(4)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
      .q(dq[0]), .qb(dqb[0]), .rise(drise[0]), .conflict(dconf[0]),
      .conflict_cnt(c0), .any_q(dany[0]));
   sr_latch_bank #(.CH(8), .MODE(1), .EDGE(1), .CNT_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
      .q(dq[1]), .qb(dqb[1]), .rise(drise[1]), .conflict(dconf[1]),
      .conflict_cnt(c1), .any_q(dany[1]));
   sr_latch_bank #(.CH(8), .MODE(2), .EDGE(0), .CNT_W(2)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
      .q(dq[2]), .qb(dqb[2]), .rise(drise[2]), .conflict(dconf[2]),
      .conflict_cnt(c2), .any_q(dany[2]));
   sr_latch_bank #(.CH(8), .MODE(3), .EDGE(1), .CNT_W(4)) u3 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .s(s), .r(r),
      .q(dq[3]), .qb(dqb[3]), .rise(drise[3]), .conflict(dconf[3]),
      .conflict_cnt(c3), .any_q(dany[3]));

   always_comb begin
      dcnt[0] = {28'b0, c0};
      dcnt[1] = {30'b0, c1};
      dcnt[2] = {30'b0, c2};
      dcnt[3] = {28'b0, c3};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0][7:0] q;
      logic [3:0][7:0] rise;
      logic [3:0][7:0] conf;
      logic [3:0][7:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   const int P_MODE[4] = '{0, 1, 2, 3};
   const int P_EDGE[4] = '{0, 1, 0, 1};
   const int P_MAX[4]  = '{15, 3, 3, 15};

   logic [7:0] mq[4];
   logic [7:0] mrise[4];
   logic [7:0] mconf[4];
   int         mcnt[4];
   logic [7:0] msd;
   logic [7:0] mrd;

   function automatic void chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s u%0d: got=%0h expected=%0h @%0t", nm, k, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         mq[k] = '0; mrise[k] = '0; mconf[k] = '0; mcnt[k] = 0;
      end
      msd = '0;
      mrd = '0;
   endtask

   task automatic model_step(input logic [7:0] sv, input logic [7:0] rv,
                             input logic env, input logic clrv);
      logic [7:0] nq;
      bit         a, b, anyc;
      for (int k = 0; k < 4; k++) begin
         anyc = 0;
         nq   = mq[k];
         if (clrv) begin
            mq[k] = '0; mrise[k] = '0; mconf[k] = '0; mcnt[k] = 0;
         end else if (env) begin
            for (int i = 0; i < 8; i++) begin
               a = sv[i] && !(P_EDGE[k] == 1 && msd[i]);
               b = rv[i] && !(P_EDGE[k] == 1 && mrd[i]);
               if (a && b) begin
                  anyc = 1;
                  mconf[k][i] = 1'b1;
                  if (P_MODE[k] == 0)      nq[i] = 1'b0;
                  else if (P_MODE[k] == 1) nq[i] = 1'b1;
                  else if (P_MODE[k] == 3) nq[i] = !mq[k][i];
               end else if (a) begin
                  nq[i] = 1'b1;
               end else if (b) begin
                  nq[i] = 1'b0;
               end
            end
            mrise[k] = nq & ~mq[k];
            mq[k]    = nq;
            if (anyc && mcnt[k] < P_MAX[k]) mcnt[k] = mcnt[k] + 1;
         end else begin
            mrise[k] = '0;
         end
      end
      msd = sv;
      mrd = rv;
   endtask

   task automatic push();
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         e.q[k]    = mq[k];
         e.rise[k] = mrise[k];
         e.conf[k] = mconf[k];
         e.cnt[k]  = 8'(mcnt[k]);
      end
      sb.push_back(e);
   endtask

   task automatic step(input logic [7:0] sv, input logic [7:0] rv,
                       input logic env, input logic clrv);
      @(negedge clk);
      rst_n = 1'b1;
      s = sv; r = rv; en = env; clr = clrv;
      model_step(sv, rv, env, clrv);
      push();
   endtask

   // Asserted mid-cycle: outputs must clear before any clock edge arrives.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      s = '0; r = '0; en = 1'b0; clr = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rst_q", k, {24'b0, dq[k]}, 32'h00);
         chk("rst_qb", k, {24'b0, dqb[k]}, 32'hFF);
         chk("rst_rise", k, {24'b0, drise[k]}, 32'h00);
         chk("rst_conf", k, {24'b0, dconf[k]}, 32'h00);
         chk("rst_cnt", k, dcnt[k], 32'h0);
         chk("rst_anyq", k, {31'b0, dany[k]}, 32'h0);
      end
      model_reset();
      push();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int k = 0; k < 4; k++) begin
               chk("q", k, {24'b0, dq[k]}, {24'b0, e.q[k]});
               chk("qb", k, {24'b0, dqb[k]}, {24'b0, 8'(~e.q[k])});
               chk("rise", k, {24'b0, drise[k]}, {24'b0, e.rise[k]});
               chk("conflict", k, {24'b0, dconf[k]}, {24'b0, e.conf[k]});
               chk("conflict_cnt", k, dcnt[k], {24'b0, e.cnt[k]});
               chk("any_q", k, {31'b0, dany[k]}, {31'b0, |e.q[k]});
            end
         end
      end
   end

   initial begin : stimulus
      logic [7:0] sv, rv;
      rst_n = 1'b1; en = 1'b0; clr = 1'b0; s = '0; r = '0;
      model_reset();
      do_reset();

      // single set, rise pulse for one cycle
      step(8'h01, 8'h00, 1, 0);
      step(8'h00, 8'h00, 1, 0);
      step(8'h00, 8'h00, 1, 0);

      // S=R=1 resolution on channel 3
      step(8'h00, 8'h00, 1, 1);
      step(8'h08, 8'h00, 1, 0);
      step(8'h08, 8'h08, 1, 0);
      step(8'h00, 8'h00, 1, 0);

      // held set after a reset; second reset pulse while set still high
      step(8'h00, 8'h04, 1, 0);
      repeat (5) step(8'h04, 8'h00, 1, 0);
      step(8'h04, 8'h04, 1, 0);
      step(8'h04, 8'h00, 1, 0);
      step(8'h00, 8'h00, 1, 0);

      // consecutive conflicts reach saturation, then clr beats set
      step(8'h00, 8'h00, 1, 1);
      for (int i = 0; i < 5; i++) step(8'(1 << i), 8'(1 << i), 1, 0);
      step(8'hFF, 8'h00, 1, 1);
      step(8'h00, 8'h00, 1, 0);

      // disabled cycles freeze state
      step(8'hAA, 8'h55, 0, 0);
      step(8'hAA, 8'h55, 0, 0);
      step(8'hAA, 8'h55, 1, 0);
      step(8'h00, 8'h00, 1, 0);

      // asynchronous reset with all flags set
      step(8'hFF, 8'h00, 1, 0);
      step(8'h00, 8'h00, 1, 0);
      do_reset();
      step(8'h00, 8'h00, 1, 0);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            sv = 8'($urandom & $urandom);
            rv = 8'($urandom & $urandom);
            step(sv, rv, $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0);
         end
      end

      repeat (4) @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got=%0d pending expected=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
